// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus bundle: control strobes, memory request channel and
// decode-side queue head. The master view belongs to the fetch buffer,
// the slave view to the surrounding core (decode, memory, branch unit).
interface fetch_buffer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Fetch control
    logic               halt;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    // Memory request channel
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    // Decode-side queue head
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [CNT_W-1:0]   count;

    modport master (
        input  halt, redirect_valid, redirect_pc,
        input  mem_ack, mem_rdata,
        input  out_ready,
        output mem_req, mem_addr,
        output out_valid, out_instr, out_pc, count
    );

    modport slave (
        output halt, redirect_valid, redirect_pc,
        output mem_ack, mem_rdata,
        output out_ready,
        input  mem_req, mem_addr,
        input  out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues one memory read at a time from fetch_pc,
// queues {pc, instruction} pairs for decode, and handles redirects by
// flushing the queue and discarding any response still in flight.
module fetch_buffer #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0064
) (
    input logic            clk,
    input logic            rst,
    fetch_buffer_if.master bus
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_W / 8);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t             state;
    logic               req_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  fetch_pc_inc;

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_next;

    logic               redirect;
    logic               ack;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic               issue_now;
    logic               issue_next;

    assign redirect     = bus.redirect_valid;
    assign ack          = bus.mem_ack;
    assign fetch_pc_inc = fetch_pc + STEP;
    assign head_valid   = (count_q != '0);

    // A response is kept only when it answers a live request and no redirect
    // arrives with it; a redirect also supersedes any pop in the same cycle.
    assign push = (state == S_REQ) && ack && !redirect;
    assign pop  = head_valid && bus.out_ready && !redirect;

    // Occupancy after this cycle's push/pop/flush.
    // NOTE: always_comb assigns a default first so no path leaves count_next
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_next = count_q;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Issue from IDLE looks at the current occupancy; back-to-back reissue
    // after a completed request looks at occupancy after the push/pop, so a
    // request is only ever made when its response is guaranteed a slot.
    assign issue_now  = !bus.halt && !redirect && (count_q < FULL);
    assign issue_next = !bus.halt && !redirect && (count_next < FULL);

    // Memory FSM: one outstanding request, registered mem_req/mem_addr held
    // stable from entry to REQ/DROP through the ack cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= bus.redirect_pc;
                    end else if (issue_now) begin
                        state  <= S_REQ;
                        req_q  <= 1'b1;
                        addr_q <= fetch_pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        fetch_pc <= bus.redirect_pc;
                        if (ack) begin
                            state <= S_IDLE;
                            req_q <= 1'b0;
                        end else begin
                            state <= S_DROP;
                        end
                    end else if (ack) begin
                        fetch_pc <= fetch_pc_inc;
                        if (issue_next) begin
                            addr_q <= fetch_pc_inc;
                        end else begin
                            state <= S_IDLE;
                            req_q <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        fetch_pc <= bus.redirect_pc;
                    end
                    if (ack) begin
                        state <= S_IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Queue storage write.
    // NOTE: the entry array is deliberately not reset; the head outputs are
    // gated by out_valid, so stale contents can never reach decode.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.mem_rdata;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = addr_q;
    assign bus.count     = count_q;
    assign bus.out_valid = head_valid;
    assign bus.out_instr = head_valid ? instr_q[rd_ptr] : '0;
    assign bus.out_pc    = head_valid ? pc_q[rd_ptr]    : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer: a simple memory responder returns
// the request address as data after a programmable number of wait cycles.
`timescale 1ns/1ps
module tb_fetch_buffer;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   mem_lat;
    int   wait_cnt;
    bit   stray_ack;

    fetch_buffer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(16'h0064)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks after mem_lat cycles of mem_req, data = address.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = 0;
        forever begin
            @(negedge clk);
            if (stray_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 16'hDEAD;
            end else if (rst) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_req) begin
                if (bus.mem_ack) wait_cnt = 0;
                if (wait_cnt >= mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic h, input logic rdy, input int lat);
        rst                = 1'b1;
        stray_ack          = 1'b0;
        bus.halt           = h;
        bus.out_ready      = rdy;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        mem_lat            = lat;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        stray_ack          = 1'b0;
        bus.halt           = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        mem_lat            = 0;
        repeat (3) step();
        tests_run++;
        if (bus.mem_req !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mem_req: got %b required 0", bus.mem_req);
        end
        tests_run++;
        if (bus.mem_addr !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_mem_addr: got %h required 0000", bus.mem_addr);
        end
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_queue: got count=%0d valid=%b required 0/0", bus.count, bus.out_valid);
        end
        tests_run++;
        if (bus.out_instr !== 16'h0000 || bus.out_pc !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_head: got instr=%h pc=%h required 0000/0000", bus.out_instr, bus.out_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        bit ok;
        do_reset(1'b0, 1'b1, 0);
        step();
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0064) begin
            tests_failed++; $display("FAIL first_request: got req=%b addr=%h required 1/0064", bus.mem_req, bus.mem_addr);
        end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.out_valid === 1'b1) ok = 1'b1; else step();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL seq_fill: got no out_valid required valid within 10 cycles");
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'(16'h0064 + 2 * k) || bus.out_instr !== 16'(16'h0064 + 2 * k)) begin
                tests_failed++;
                $display("FAIL seq_head%0d: got valid=%b pc=%h instr=%h required 1/%h/%h", k, bus.out_valid,
                         bus.out_pc, bus.out_instr, 16'(16'h0064 + 2 * k), 16'(16'h0064 + 2 * k));
            end
            step();
        end
    endtask

    task automatic test_full_then_resume();
        logic [15:0] popped [5];
        int          npop;
        bit          seen_req;
        do_reset(1'b0, 1'b0, 0);
        repeat (10) step();
        tests_run++;
        if (bus.count !== 3'd4 || bus.mem_req !== 1'b0) begin
            tests_failed++; $display("FAIL full_stop: got count=%0d req=%b required 4/0", bus.count, bus.mem_req);
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0064) begin
            tests_failed++; $display("FAIL full_head: got valid=%b pc=%h required 1/0064", bus.out_valid, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        npop     = 0;
        seen_req = 1'b0;
        for (int i = 0; i < 12 && npop < 5; i++) begin
            if (bus.mem_req === 1'b1 && !seen_req) begin
                seen_req = 1'b1;
                tests_run++;
                if (bus.mem_addr !== 16'h006C) begin
                    tests_failed++; $display("FAIL resume_addr: got %h required 006C", bus.mem_addr);
                end
            end
            if (bus.out_valid === 1'b1) begin
                popped[npop] = bus.out_pc;
                npop++;
            end
            step();
        end
        tests_run++;
        if (!seen_req || npop != 5) begin
            tests_failed++; $display("FAIL resume_progress: got req_seen=%b pops=%0d required 1/5", seen_req, npop);
        end
        for (int k = 0; k < npop; k++) begin
            tests_run++;
            if (popped[k] !== 16'(16'h0064 + 2 * k)) begin
                tests_failed++; $display("FAIL resume_order%0d: got %h required %h", k, popped[k], 16'(16'h0064 + 2 * k));
            end
        end
    endtask

    task automatic test_redirect_waiting();
        bit seen;
        do_reset(1'b0, 1'b1, 3);
        step();
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0064) begin
            tests_failed++; $display("FAIL rw_issue: got req=%b addr=%h required 1/0064", bus.mem_req, bus.mem_addr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0200;
        step();
        bus.redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            tests_run++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0064 || bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rw_hold: got req=%b addr=%h valid=%b required 1/0064/0", bus.mem_req, bus.mem_addr, bus.out_valid);
            end
            if (bus.mem_ack === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL rw_ack_timeout: got no mem_ack required ack within 10 cycles");
        end
        step();
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_discard: got req=%b count=%0d valid=%b required 0/0/0", bus.mem_req, bus.count, bus.out_valid);
        end
        step();
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0200) begin
            tests_failed++; $display("FAIL rw_new_addr: got req=%b addr=%h required 1/0200", bus.mem_req, bus.mem_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || bus.out_pc !== 16'h0200) begin
            tests_failed++; $display("FAIL rw_first_out: got valid=%b pc=%h required 1/0200", seen, bus.out_pc);
        end
    endtask

    task automatic test_redirect_with_ack();
        bit seen;
        do_reset(1'b0, 1'b0, 2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.mem_ack === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL ra_ack_timeout: got no mem_ack required ack within 10 cycles");
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0300;
        step();
        bus.redirect_valid = 1'b0;
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ra_discard: got req=%b count=%0d valid=%b required 0/0/0", bus.mem_req, bus.count, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || bus.out_pc !== 16'h0300 || bus.out_instr !== 16'h0300) begin
            tests_failed++;
            $display("FAIL ra_first_out: got valid=%b pc=%h instr=%h required 1/0300/0300", seen, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_halt();
        bit seen;
        int extra_req;
        do_reset(1'b0, 1'b0, 3);
        step();
        tests_run++;
        if (bus.mem_req !== 1'b1) begin
            tests_failed++; $display("FAIL halt_issue: got req=%b required 1", bus.mem_req);
        end
        bus.halt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.mem_ack === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL halt_ack_timeout: got no mem_ack required ack within 10 cycles");
        end
        extra_req = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.mem_req === 1'b1) extra_req++;
        end
        tests_run++;
        if (extra_req != 0) begin
            tests_failed++; $display("FAIL halt_no_issue: got %0d request cycles required 0", extra_req);
        end
        tests_run++;
        if (bus.count !== 3'd1 || bus.out_pc !== 16'h0064) begin
            tests_failed++; $display("FAIL halt_enqueued: got count=%0d pc=%h required 1/0064", bus.count, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        repeat (3) step();
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_drain: got count=%0d valid=%b req=%b required 0/0/0", bus.count, bus.out_valid, bus.mem_req);
        end
        bus.halt = 1'b0;
    endtask

    task automatic test_wrap();
        bit seen;
        do_reset(1'b1, 1'b1, 0);
        step();
        tests_run++;
        if (bus.mem_req !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_halted: got req=%b required 0", bus.mem_req);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFE;
        step();
        bus.redirect_valid = 1'b0;
        bus.halt           = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL wrap_fill: got no out_valid required valid within 10 cycles");
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'(16'hFFFE + 2 * k)) begin
                tests_failed++;
                $display("FAIL wrap_head%0d: got valid=%b pc=%h required 1/%h", k, bus.out_valid, bus.out_pc, 16'(16'hFFFE + 2 * k));
            end
            step();
        end
    endtask

    task automatic test_reset_outstanding();
        do_reset(1'b0, 1'b0, 0);
        repeat (3) step();
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ro_busy: got req=%b valid=%b required 1/1", bus.mem_req, bus.out_valid);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.count !== 3'd0 ||
            bus.out_valid !== 1'b0 || bus.out_pc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL ro_async: got req=%b addr=%h count=%0d valid=%b pc=%h required 0/0000/0/0/0000",
                     bus.mem_req, bus.mem_addr, bus.count, bus.out_valid, bus.out_pc);
        end
        stray_ack = 1'b1;
        bus.halt  = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL ro_stray_ack: got count=%0d valid=%b req=%b required 0/0/0", bus.count, bus.out_valid, bus.mem_req);
        end
        stray_ack = 1'b0;
        step();
        bus.halt = 1'b0;
        step();
        tests_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0064) begin
            tests_failed++; $display("FAIL ro_restart: got req=%b addr=%h required 1/0064", bus.mem_req, bus.mem_addr);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        stray_ack    = 1'b0;
        mem_lat      = 0;
        rst          = 1'b1;
        test_reset();
        test_sequential();
        test_full_then_resume();
        test_redirect_waiting();
        test_redirect_with_ack();
        test_halt();
        test_wrap();
        test_reset_outstanding();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter ADDR_W, 16, fetch address width in bits.
REQ-002 Parameter INSTR_W, 16, instruction width; multiple of 8.
REQ-003 Parameter DEPTH, 4, queue entries; power of 2, >= 2.
REQ-004 Parameter RESET_PC, 16'h0064, first fetch address after reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 halt  input  1  stops issuing new memory requests.
REQ-008 redirect_valid  input  1  branch/jump redirect strobe; one cycle.
REQ-009 redirect_pc  input  ADDR_W  new fetch address.
REQ-010 mem_req  output  1  memory read request.
REQ-011 mem_addr  output  ADDR_W  request address.
REQ-012 mem_ack  input  1  request completion; mem_rdata valid this cycle.
REQ-013 mem_rdata  input  INSTR_W  fetched instruction word.
REQ-014 out_valid  output  1  queue head available to decode.
REQ-015 out_ready  input  1  decode accepts head.
REQ-016 out_instr  output  INSTR_W  head instruction.
REQ-017 out_pc  output  ADDR_W  address of head instruction.
REQ-018 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 fetch_pc register SHALL hold the next address to request; it advances by STEP = INSTR_W/8 on each enqueued response, wrapping modulo 2^ADDR_W.
REQ-020 Memory FSM SHALL have states IDLE (mem_req=0), REQ (mem_req=1, waiting), and DROP (mem_req=1, response to be discarded).
REQ-021 IDLE->REQ SHALL occur when halt=0, redirect_valid=0, and count < DEPTH; mem_addr latches fetch_pc on entry.
REQ-022 mem_req and mem_addr SHALL stay stable from REQ/DROP entry through the mem_ack cycle inclusive; only one request outstanding.
REQ-023 REQ with mem_ack and no redirect SHALL push {fetch_pc, mem_rdata} into the queue and advance fetch_pc.
REQ-024 After REQ with mem_ack, the FSM SHALL re-enter REQ next cycle if the REQ-021 condition holds after the push/pop, else IDLE (back-to-back: one fetch per cycle with zero-wait memory).
REQ-025 redirect_valid in IDLE SHALL load fetch_pc=redirect_pc; a request may issue the following cycle.
REQ-026 redirect_valid in REQ without mem_ack SHALL move to DROP and load fetch_pc=redirect_pc.
REQ-027 redirect_valid in REQ with mem_ack in the same cycle SHALL discard mem_rdata, load fetch_pc=redirect_pc, and go to IDLE.
REQ-028 DROP with mem_ack SHALL discard mem_rdata and go to IDLE; a further redirect in DROP only reloads fetch_pc.
REQ-029 redirect_valid SHALL flush the queue (count=0 next cycle); a same-cycle pop is superseded by the flush.
REQ-030 halt SHALL block only new issue: a pending REQ completes and enqueues, and the queue keeps draining.
REQ-031 Queue SHALL be FIFO; out_valid = (count != 0); pop when out_valid && out_ready; simultaneous push and pop leaves count unchanged.
REQ-032 Overflow SHALL be impossible by construction (issue requires count < DEPTH); a pop with count=0 SHALL be ignored.
REQ-033 out_instr/out_pc SHALL be driven from the head entry with no combinational path from mem_rdata; enqueue-to-out_valid latency is 1 cycle.

Reset
REQ-034 rst SHALL immediately force state=IDLE, mem_req=0, mem_addr=0, fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0.
REQ-035 rst asserted while a request is outstanding SHALL abandon it; any mem_ack during or after reset without a new request SHALL be ignored.
REQ-036 The first request after reset release SHALL be to RESET_PC on the first clk edge with rst low and halt low.

Verification
REQ-037 Reset, zero-wait memory returning addr-as-data, out_ready=1 -> out_pc sequence 0x64, 0x66, 0x68, 0x6A; one instruction per cycle after the pipeline fills.
REQ-038 out_ready=0, DEPTH=4 -> exactly 4 entries enqueued, count=4, mem_req=0; raise out_ready -> fetching resumes at 0x6C.
REQ-039 Redirect to 0x0200 while REQ waits 3 cycles for ack -> mem_addr stays 0x64 until ack, data discarded, queue empty, next mem_addr=0x0200.
REQ-040 Redirect coincident with mem_ack -> nothing enqueued, next out_pc=redirect_pc.
REQ-041 halt=1 with one request pending -> that word enqueued, no further mem_req, queue drains to count=0.
REQ-042 Redirect to 0xFFFE, zero-wait memory -> out_pc 0xFFFE then 0x0000.
